cnt_bank_snap: RTL and testbench

- Parametrised bank of N_CH independent up/down counters of WIDTH bits each, all clocked by one clock.
- Each counter has clear, load and enable controls, and selectable wrap or saturate behaviour.
- An atomic snapshot port captures every channel's count on a single edge with defined sample semantics, so the value read is never ambiguous at the edge that updates the count.
- Used as the shared event/cycle counter block for lab benches and small datapaths.

---
 rtl/cnt_bank_snap.sv | 52 +++++
 tb/tb_cnt_bank_snap.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/cnt_bank_snap.sv
// cnt_bank_snap: bank of independent up/down counters with an atomic snapshot port.
// Snapshot captures the counts present before the edge that samples snap_req_i.
module cnt_bank_snap #(
  parameter int N_CH     = 4,
  parameter int WIDTH    = 8,
  parameter int SATURATE = 0,
  parameter int RST_VAL  = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_CH-1:0]         en_i,
  input  logic [N_CH-1:0]         dn_i,
  input  logic [N_CH-1:0]         clr_i,
  input  logic [N_CH-1:0]         ld_i,
  input  logic [N_CH*WIDTH-1:0]   ld_val_i,
  output logic [N_CH*WIDTH-1:0]   cnt_o,
  output logic [N_CH-1:0]         tc_o,
  input  logic                    snap_req_i,
  output logic [N_CH*WIDTH-1:0]   snap_data_o,
  output logic                    snap_valid_o
);
  localparam logic [WIDTH-1:0] MAX = '1;
  localparam logic [WIDTH-1:0] RV  = WIDTH'(RST_VAL);
  logic [N_CH*WIDTH-1:0] cnt_nxt;
  logic [N_CH-1:0]       tc_nxt;
  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    logic [WIDTH-1:0] c;
    logic             at_bnd;
    assign c      = cnt_o[i*WIDTH +: WIDTH];
    assign at_bnd = dn_i[i] ? (c == '0) : (c == MAX);
    // saturate mode pins the count at the bound; tc still fires
    assign cnt_nxt[i*WIDTH +: WIDTH] = clr_i[i] ? RV :
                                       ld_i[i] ? ld_val_i[i*WIDTH +: WIDTH] :
                                       !en_i[i] ? c :
                                       (at_bnd && SATURATE != 0) ? c :
                                       dn_i[i] ? c - 1'b1 : c + 1'b1;
    assign tc_nxt[i] = !clr_i[i] && !ld_i[i] && en_i[i] && at_bnd;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_o        <= {N_CH{RV}};
      tc_o         <= '0;
      snap_data_o  <= '0;
      snap_valid_o <= 1'b0;
    end else begin
      cnt_o        <= cnt_nxt;
      tc_o         <= tc_nxt;
      snap_valid_o <= snap_req_i;
      if (snap_req_i) snap_data_o <= cnt_o;
    end
  end
endmodule

// File: tb/tb_cnt_bank_snap.sv
// tb_cnt_bank_snap: directed + random checks of wrap and saturate instances against an arithmetic model.
module tb_cnt_bank_snap;
  localparam int N = 4;
  localparam int W = 8;
  logic clk = 0;
  logic rst = 1;
  logic [N-1:0] en = '0, dn = '0, clr = '0, ld = '0;
  logic [N*W-1:0] ldv = '0;
  logic snap_req = 0;
  logic [N*W-1:0] cnt_w [2];
  logic [N*W-1:0] snap_w [2];
  logic [N-1:0] tc_w [2];
  logic sv_w [2];
  int checks = 0, errors = 0;
  int mc [2][N];
  bit mt [2][N];
  logic [N*W-1:0] ms [2];
  bit mv [2];

  always #5 clk = ~clk;

  cnt_bank_snap #(.N_CH(N), .WIDTH(W), .SATURATE(0), .RST_VAL(0)) u_wrap (
    .clk(clk), .rst(rst), .en_i(en), .dn_i(dn), .clr_i(clr), .ld_i(ld), .ld_val_i(ldv),
    .cnt_o(cnt_w[0]), .tc_o(tc_w[0]), .snap_req_i(snap_req), .snap_data_o(snap_w[0]),
    .snap_valid_o(sv_w[0]));
  cnt_bank_snap #(.N_CH(N), .WIDTH(W), .SATURATE(1), .RST_VAL(0)) u_sat (
    .clk(clk), .rst(rst), .en_i(en), .dn_i(dn), .clr_i(clr), .ld_i(ld), .ld_val_i(ldv),
    .cnt_o(cnt_w[1]), .tc_o(tc_w[1]), .snap_req_i(snap_req), .snap_data_o(snap_w[1]),
    .snap_valid_o(sv_w[1]));

  function automatic logic [N*W-1:0] pk(int d);
    logic [N*W-1:0] r;
    for (int i = 0; i < N; i++) r[i*W +: W] = mc[d][i][W-1:0];
    return r;
  endfunction

  function automatic logic [N-1:0] pt(int d);
    logic [N-1:0] r;
    for (int i = 0; i < N; i++) r[i] = mt[d][i];
    return r;
  endfunction

  task automatic m_reset();
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < N; i++) begin mc[d][i] = 0; mt[d][i] = 0; end
      ms[d] = '0;
      mv[d] = 0;
    end
  endtask

  // one clock edge of the model; d=1 is the saturating instance
  task automatic m_edge();
    int mx = (1 << W) - 1;
    for (int d = 0; d < 2; d++) begin
      mv[d] = snap_req;
      if (snap_req) ms[d] = pk(d);
      for (int i = 0; i < N; i++) begin
        mt[d][i] = 0;
        if (clr[i]) mc[d][i] = 0;
        else if (ld[i]) mc[d][i] = int'(ldv[i*W +: W]);
        else if (en[i]) begin
          if (dn[i] && mc[d][i] == 0) begin mt[d][i] = 1; mc[d][i] = d ? 0 : mx; end
          else if (!dn[i] && mc[d][i] == mx) begin mt[d][i] = 1; mc[d][i] = d ? mx : 0; end
          else mc[d][i] = (mc[d][i] + (dn[i] ? -1 : 1) + (mx + 1)) % (mx + 1);
        end
      end
    end
  endtask

  task automatic chk(string tag, logic [N*W-1:0] obs, logic [N*W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(string tag);
    for (int d = 0; d < 2; d++) begin
      chk({tag, d ? "_sat_cnt" : "_wrap_cnt"}, cnt_w[d], pk(d));
      chk({tag, d ? "_sat_tc" : "_wrap_tc"}, {{(N*W-N){1'b0}}, tc_w[d]}, {{(N*W-N){1'b0}}, pt(d)});
      chk({tag, d ? "_sat_snap" : "_wrap_snap"}, snap_w[d], ms[d]);
      chk({tag, d ? "_sat_sv" : "_wrap_sv"}, {{(N*W-1){1'b0}}, sv_w[d]}, {{(N*W-1){1'b0}}, mv[d]});
    end
  endtask

  task automatic cyc(string tag);
    @(posedge clk);
    m_edge();
    #1 chk_all(tag);
    @(negedge clk);
  endtask

  task automatic idle();
    en = '0; dn = '0; clr = '0; ld = '0; snap_req = 0;
  endtask

  initial begin
    m_reset();
    en = '1; ld = '1; ldv = '1; snap_req = 1;
    repeat (2) @(posedge clk);
    #1 chk_all("reset_hold");
    @(negedge clk);
    idle();
    rst = 0;
    // 1: ch0 counts 10 up
    en = 4'b0001;
    repeat (10) cyc("t1");
    chk("t1_ch0", {24'h0, cnt_w[0][7:0]}, 32'h0A);
    idle();
    // 2: wrap from 0xFE on ch1
    ld = 4'b0010; ldv = 32'h0000_FE00;
    cyc("t2_ld");
    ld = '0; en = 4'b0010;
    cyc("t2_a");
    cyc("t2_b");
    chk("t2_wrap_ch1", {24'h0, cnt_w[0][15:8]}, 32'h00);
    chk("t2_wrap_tc", {28'h0, tc_w[0]}, 32'h2);
    cyc("t2_c");
    idle();
    // 3: saturate down on ch2
    ld = 4'b0100; ldv = 32'h0001_0000;
    cyc("t3_ld");
    ld = '0; en = 4'b0100; dn = 4'b0100;
    repeat (4) cyc("t3");
    chk("t3_sat_ch2", {24'h0, cnt_w[1][23:16]}, 32'h00);
    chk("t3_sat_tc", {28'h0, tc_w[1]}, 32'h4);
    idle();
    // 4: clr beats ld and en
    en = 4'b1000;
    repeat (3) cyc("t4_pre");
    clr = 4'b1000; ld = 4'b1000; ldv = 32'h5500_0000;
    cyc("t4");
    chk("t4_ch3", {24'h0, cnt_w[0][31:24]}, 32'h00);
    idle();
    // 5: snapshot sees pre-update value
    ld = 4'b0001; ldv = 32'h0000_0006;
    cyc("t5_ld");
    ld = '0; en = 4'b0001;
    cyc("t5_a");
    snap_req = 1;
    cyc("t5_snap");
    chk("t5_snap_ch0", {24'h0, snap_w[0][7:0]}, 32'h07);
    snap_req = 0;
    cyc("t5_after");
    idle();
    // 6: async reset drops a just-issued snapshot
    en = 4'b1111; snap_req = 1;
    @(posedge clk);
    m_edge();
    #1 chk_all("t6_pre");
    #2 rst = 1;
    #1 m_reset();
    chk_all("t6_async");
    @(negedge clk);
    idle();
    rst = 0;
    en = 4'b0001;
    cyc("t6_first_edge");
    // random traffic
    for (int k = 0; k < 400; k++) begin
      en = 4'($urandom);
      dn = 4'($urandom);
      clr = 4'($urandom) & 4'($urandom) & 4'($urandom);
      ld = 4'($urandom) & 4'($urandom);
      ldv = $urandom;
      if ($urandom_range(0, 3) == 0) ldv = 32'hFFFE_0100;
      snap_req = 1'($urandom);
      cyc("rand");
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
